// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder
// ----------------------
// Streaming extended-Hamming (SECDED) decoder with a valid/ready handshake
// and a two-register pipeline. It corrects any single-bit error and flags
// any double-bit error.
//
// Codeword layout: bit 0 is overall parity, so the XOR of every bit is 0 for
// a clean word. Bits 1..CODE_W-1 are Hamming positions. Power-of-two
// positions hold check bits. The other positions hold data[0]..data[DATA_W-1]
// in ascending order.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake for codeword
//   codeword            received codeword, DATA_W+PARITY_W+1 bits
//   out_valid/out_ready output handshake for the decoded result
//   data                corrected data (raw data bits when uncorrectable)
//   syndrome            Hamming syndrome of the codeword
//   err_corrected       a single-bit error was corrected
//   err_uncorrectable   a double-bit error was detected
//   cnt_clr             synchronous clear for the error counters
//   cnt_corrected       saturating count of corrected results delivered
//   cnt_uncorrectable   saturating count of uncorrectable results delivered
//
// Build option: define HAMMING_SECDED_STATS_EN to build the error counters.
// Without it, the counters read as 0 and cnt_clr is ignored.
module hamming_secded_decoder #(
  parameter int DATA_W   = 4,
  parameter int PARITY_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W+PARITY_W:0]   codeword,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          data,
  output logic [PARITY_W-1:0]        syndrome,
  output logic                       err_corrected,
  output logic                       err_uncorrectable,
  input  logic                       cnt_clr,
  output logic [CNT_W-1:0]           cnt_corrected,
  output logic [CNT_W-1:0]           cnt_uncorrectable
);

  localparam int CODE_W = DATA_W + PARITY_W + 1;

  // The syndrome must be able to name every position of the codeword.
  generate
    if ((2 ** PARITY_W) < CODE_W) begin : g_bad_params
      $error("hamming_secded_decoder: PARITY_W too small for DATA_W");
    end
  endgenerate

  // This function returns the codeword position of data bit idx. It counts
  // the non-power-of-two positions from 1 upward.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  logic              s1_valid;
  logic [CODE_W-1:0] s1_cw;
  logic              s2_advance;

  // Stage 2 can take a new word when it is empty or is being drained.
  // Stage 1 can take a new word when it is empty or can pass its word on.
  assign s2_advance = !out_valid || out_ready;
  assign in_ready   = !s1_valid || s2_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) s1_cw <= codeword;
    end
  end

  logic [PARITY_W-1:0] syn;
  logic                pe;
  logic                syn_in_range;
  logic                single_err;
  logic                double_err;
  logic [CODE_W-1:0]   fixed_cw;
  logic [DATA_W-1:0]   fixed_data;

  // The syndrome is the XOR of the indices of all set Hamming positions.
  always_comb begin
    syn = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (s1_cw[p]) syn = syn ^ PARITY_W'(p);
    end
  end

  assign pe = ^s1_cw;

  // Classification uses the syndrome and the overall parity bit pe.
  // If pe is set, there is a single error, unless the syndrome points past
  // the end of the word. If pe is clear and the syndrome is nonzero, there
  // are two errors. A syndrome of 0 with pe set means bit 0 itself flipped.
  assign syn_in_range = (32'(syn) < 32'(CODE_W));
  assign single_err   = pe && syn_in_range;
  assign double_err   = pe ? !syn_in_range : (syn != '0);

  always_comb begin
    fixed_cw = s1_cw;
    if (single_err) fixed_cw = s1_cw ^ (CODE_W'(1) << syn);
  end

  // fixed_cw equals the raw word unless a correction applies, so a single
  // extraction covers the clean, corrected and raw-uncorrectable cases.
  generate
    for (genvar i = 0; i < DATA_W; i++) begin : g_extract
      assign fixed_data[i] = fixed_cw[data_pos(i)];
    end
  endgenerate

  // Stage 2 holds the result. The flags are cleared when a bubble moves in,
  // so they are 0 whenever out_valid is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      data              <= '0;
      syndrome          <= '0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else if (s2_advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data              <= fixed_data;
        syndrome          <= syn;
        err_corrected     <= single_err;
        err_uncorrectable <= double_err;
      end else begin
        err_corrected     <= 1'b0;
        err_uncorrectable <= 1'b0;
      end
    end
  end

`ifdef HAMMING_SECDED_STATS_EN
  logic out_fire;
  assign out_fire = out_valid && out_ready;

  // The counters count only results that the consumer actually accepted.
  // Clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (cnt_clr) begin
      cnt_corrected     <= '0;
      cnt_uncorrectable <= '0;
    end else if (out_fire) begin
      if (err_corrected && (cnt_corrected != '1))
        cnt_corrected <= cnt_corrected + CNT_W'(1);
      if (err_uncorrectable && (cnt_uncorrectable != '1))
        cnt_uncorrectable <= cnt_uncorrectable + CNT_W'(1);
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr    = cnt_clr;
  assign cnt_corrected     = '0;
  assign cnt_uncorrectable = '0;
`endif

endmodule

// File: doc/hamming_secded_decoder.md
Name: hamming_secded_decoder

Overview:
Parametrised extended-Hamming (SECDED) decoder for streaming codewords. It generalises the fixed [7,4] decoder to any DATA_W/PARITY_W pair and adds an overall parity bit for double-error detection. It also adds a valid/ready handshake, a 2-stage registered pipeline and per-error status. It sits between the link/memory read path and the consumer of decoded data.

Parameters:
DATA_W, 4, data bits per codeword
PARITY_W, 3, Hamming check bits; elaboration error unless 2**PARITY_W >= DATA_W+PARITY_W+1
CNT_W, 16, width of saturating error counters (optional feature only)
(derived) CODE_W = DATA_W+PARITY_W+1

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  codeword valid
in_ready  out  1  decoder can accept codeword
codeword  in  CODE_W  received codeword
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
data  out  DATA_W  decoded (corrected) data
syndrome  out  PARITY_W  Hamming syndrome of the accepted codeword
err_corrected  out  1  single-bit error found and corrected
err_uncorrectable  out  1  double-bit error detected
cnt_clr  in  1  synchronous clear of counters (optional feature)
cnt_corrected  out  CNT_W  count of corrected results (optional feature)
cnt_uncorrectable  out  CNT_W  count of uncorrectable results (optional feature)

Behaviour:
- Bit layout: bit 0 = overall parity, so XOR of all CODE_W bits is 0 for a clean word. Bits 1..CODE_W-1 = Hamming positions. Positions that are powers of two carry check bits; the remaining positions carry data[0]..data[DATA_W-1] in ascending order.
- Syndrome: XOR of the position indices of all set bits in positions 1..CODE_W-1. Overall parity check: pe = XOR of all bits.
- Classification:
  - syn=0, pe=0: clean.
  - pe=1: single error. Flip the bit at position syn; syn=0 means the error is in bit 0. Data is corrected and err_corrected=1.
  - syn!=0, pe=0: double error. err_uncorrectable=1; data = raw extracted data bits, uncorrected.
  - syn >= CODE_W with pe=1: treated as uncorrectable.
- Pipeline:
  - Stage 1 registers the codeword and computes syndrome and pe.
  - Stage 2 registers corrected data and flags.
  - Latency is 2 cycles from the in_valid&&in_ready edge to out_valid when there is no backpressure.
  - Throughput is 1 word/cycle.
- Handshake:
  - Transfer occurs when valid&&ready are both high at a clock edge.
  - out_valid, data and the flags hold stable while out_valid&&!out_ready.
  - in_ready = !s1_valid || !s2_valid || out_ready; stages advance independently to fill bubbles.
  - in_ready does not depend combinationally on in_valid.
- Reset: async assert, sync deassert handled upstream. All valid bits, data, syndrome, flags and counters go to 0. in_ready=1 after reset. Reset mid-stream discards in-flight words.
- err_corrected and err_uncorrectable are mutually exclusive, and both are 0 when out_valid=0.

Optional Feature:
HAMMING_SECDED_STATS_EN
- Defined: cnt_corrected and cnt_uncorrectable increment by 1 on each output transfer (out_valid&&out_ready) carrying the matching flag. They saturate at all-ones. cnt_clr zeroes them next cycle and has priority over a same-cycle increment.
- Undefined: counters are tied to 0, cnt_clr is ignored, and no counter flops are built.

Test Plan:
- Defaults, codeword=8'hAA, out_ready=1 -> two cycles later data=4'b1011, syndrome=0, both flags 0.
- codeword=8'h8A (position 5 flipped) -> data=4'b1011, syndrome=3'd5, err_corrected=1.
- codeword=8'hAB (bit 0 flipped) -> data=4'b1011, syndrome=0, err_corrected=1.
- codeword=8'hCA (positions 5 and 6 flipped) -> syndrome=3'd3, err_uncorrectable=1, data=4'b1101 (raw).
- Stream 8'hAA, 8'h8A, 8'hCA back-to-back with out_ready held 0 for 3 cycles -> in_ready drops after 2 accepted, output holds the first result stable, then all 3 emerge in order with no loss or duplication.
- STATS_EN defined, CNT_W=2, send 8'h8A five times -> cnt_corrected saturates at 3. Pulse cnt_clr -> 0. Assert rst_n=0 mid-burst -> out_valid=0 and counters 0 immediately.
